i2c_target_regbank: RTL and testbench

- Parametrised I2C target (slave) engine plus register bank; next generation of the fixed 0x20–0x23 target datapath.
- Generalised register count, address-select width, read-only status register count and synchronizer depth.
- Adds pointer range checking, a write strobe, snapshot-coherent reads and repeated-start handling.
- Sits between the chip SCL/SDA pads (open-drain, externally pulled up) and core logic.

---
 rtl/i2c_target_regbank.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_i2c_target_regbank.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regbank.sv
// I2C target engine with an 8-bit register bank.
//
// The target sits on open-drain SCL/SDA pads and answers to the 7-bit address
// {BASE_ADDR[6:ADDR_SEL_W], addr_sel}. A write transfer carries a pointer byte
// followed by data bytes. The pointer auto-increments and wraps at REG_COUNT-1.
// A read transfer returns reg[ptr], reg[ptr+1], ... until the host NACKs.
// Registers 0..RO_COUNT-1 are read-only mirrors of status_in.
//
// Ports:
//   clock      system clock, at least 8x the SCL rate
//   reset_n    asynchronous active-low reset
//   scl_in     raw SCL pad input
//   sda_in     raw SDA pad input
//   sda_out    SDA pad drive: 0 pulls the line low, 1 releases it
//   addr_sel   low target address bits
//   status_in  read-only register sources; byte j feeds reg j
//   regs_out   packed register contents; byte j is reg j
//   wr_strobe  one-clock pulse when a writable register is updated
//   wr_index   index of the register written, valid with wr_strobe
//   busy       high from a detected START to a detected STOP
module i2c_target_regbank #(
  parameter logic [6:0]  BASE_ADDR   = 7'h20,
  parameter int unsigned ADDR_SEL_W  = 2,
  parameter int unsigned REG_COUNT   = 16,
  parameter int unsigned RO_COUNT    = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    scl_in,
  input  logic                    sda_in,
  output logic                    sda_out,
  input  logic [ADDR_SEL_W-1:0]   addr_sel,
  input  logic [8*RO_COUNT-1:0]   status_in,
  output logic [8*REG_COUNT-1:0]  regs_out,
  output logic                    wr_strobe,
  output logic [4:0]              wr_index,
  output logic                    busy
);

  localparam int unsigned IdxW     = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  localparam logic [6:0]  SelMask  = 7'((1 << ADDR_SEL_W) - 1);
  localparam logic [4:0]  LastIdx  = 5'(REG_COUNT - 1);
  localparam logic [4:0]  RoLimit  = 5'(RO_COUNT);
  localparam logic [7:0]  RegLimit = 8'(REG_COUNT);

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StPtr,
    StWack,
    StWdata,
    StRdata,
    StRdataAck
  } state_e;

  // ---------------------------------------------------------------------------
  // Pad synchronizers and edge detection. Reset to 1 (idle bus level) so that
  // leaving reset never produces a spurious START or STOP.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
      sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  logic scl_s, sda_s;
  logic scl_rise, scl_fall, sda_rise, sda_fall;
  logic start_det, stop_det;

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign sda_rise  = sda_s & ~sda_prev_q;
  assign sda_fall  = ~sda_s & sda_prev_q;
  assign start_det = scl_s & sda_fall;
  assign stop_det  = scl_s & sda_rise;

  // ---------------------------------------------------------------------------
  // Protocol state
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [4:0]  ptr_q, ptr_d;
  logic        rw_q, rw_d;
  logic        sda_out_q, sda_out_d;
  logic        busy_q, busy_d;
  logic        wr_strobe_q, wr_strobe_d;
  logic [4:0]  wr_index_q, wr_index_d;
  logic        wr_en;

  logic [7:0]  regs [REG_COUNT];
  logic [7:0]  rx_byte;
  logic [7:0]  rd_byte;
  logic [4:0]  ptr_next;
  logic [6:0]  target_addr;

  assign rx_byte     = {shift_q[6:0], sda_s};
  assign rd_byte     = regs[ptr_q[IdxW-1:0]];
  assign ptr_next    = (ptr_q == LastIdx) ? 5'd0 : ptr_q + 5'd1;
  assign target_addr = (BASE_ADDR & ~SelMask) | (7'(addr_sel) & SelMask);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'd0;
      ptr_q       <= 5'd0;
      rw_q        <= 1'b0;
      sda_out_q   <= 1'b1;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_index_q  <= 5'd0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      sda_out_q   <= sda_out_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_index_q  <= wr_index_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    sda_out_d   = sda_out_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_index_d  = wr_index_q;
    wr_en       = 1'b0;

    if (start_det) begin
      state_d   = StAddr;
      bit_cnt_d = 4'd0;
      sda_out_d = 1'b1;
      busy_d    = 1'b1;
    end else if (stop_det) begin
      state_d   = StIdle;
      sda_out_d = 1'b1;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        StAddr, StPtr, StWdata: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            // Data byte completes on its 8th rising edge; commit immediately.
            if (state_q == StWdata && bit_cnt_q == 4'd7) begin
              if (ptr_q >= RoLimit) begin
                wr_en       = 1'b1;
                wr_strobe_d = 1'b1;
                wr_index_d  = ptr_q;
              end
              ptr_d = ptr_next;
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            if (state_q == StAddr) begin
              if (shift_q[7:1] == target_addr) begin
                rw_d      = shift_q[0];
                sda_out_d = 1'b0;
                state_d   = StAddrAck;
              end else begin
                state_d   = StIdle;
              end
            end else if (state_q == StPtr) begin
              if (shift_q < RegLimit) begin
                ptr_d     = shift_q[4:0];
                sda_out_d = 1'b0;
                state_d   = StWack;
              end else begin
                state_d   = StIdle;
              end
            end else begin
              sda_out_d = 1'b0;
              state_d   = StWack;
            end
          end
        end

        StAddrAck: begin
          if (scl_fall) begin
            bit_cnt_d = 4'd0;
            if (rw_q) begin
              // Snapshot the register once per byte; first bit goes out now.
              sda_out_d = rd_byte[7];
              shift_d   = {rd_byte[6:0], 1'b0};
              state_d   = StRdata;
            end else begin
              sda_out_d = 1'b1;
              state_d   = StPtr;
            end
          end
        end

        StWack: begin
          if (scl_fall) begin
            sda_out_d = 1'b1;
            bit_cnt_d = 4'd0;
            state_d   = StWdata;
          end
        end

        StRdata: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_out_d = 1'b1;
              state_d   = StRdataAck;
            end else begin
              sda_out_d = shift_q[7];
              shift_d   = {shift_q[6:0], 1'b0};
            end
          end
        end

        StRdataAck: begin
          // bit_cnt 8 = waiting for host ACK; 0 = ACK seen, reload on falling edge.
          if (scl_rise && bit_cnt_q == 4'd8) begin
            if (!sda_s) begin
              ptr_d     = ptr_next;
              bit_cnt_d = 4'd0;
            end else begin
              state_d   = StIdle;
            end
          end else if (scl_fall && bit_cnt_q == 4'd0) begin
            sda_out_d = rd_byte[7];
            shift_d   = {rd_byte[6:0], 1'b0};
            state_d   = StRdata;
          end
        end

        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Register bank. Read-only bytes are the second stage of a 2-flop status sync.
  // ---------------------------------------------------------------------------
  logic [8*RO_COUNT-1:0] status_meta_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      status_meta_q <= '0;
    end else begin
      status_meta_q <= status_in;
    end
  end

  for (genvar j = 0; j < REG_COUNT; j++) begin : g_reg
    logic [7:0] byte_q;

    if (j < RO_COUNT) begin : g_ro
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          byte_q <= 8'd0;
        end else begin
          byte_q <= status_meta_q[8*j +: 8];
        end
      end
    end else begin : g_rw
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          byte_q <= 8'd0;
        end else if (wr_en && ptr_q == 5'(j)) begin
          byte_q <= rx_byte;
        end
      end
    end

    assign regs[j]            = byte_q;
    assign regs_out[8*j +: 8] = byte_q;
  end

  assign sda_out   = sda_out_q;
  assign busy      = busy_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_index  = wr_index_q;

endmodule

// File: tb/tb_i2c_target_regbank.sv
// Self-checking bench for i2c_target_regbank: a bit-level I2C host drives the
// DUT through a wired-AND SDA line, and every result is compared with a
// transaction-level model of the register bank.
module tb_i2c_target_regbank;

  localparam logic [6:0] Tgt = 7'h21;  // BASE_ADDR 0x20 with addr_sel 01

  logic         clock = 1'b0;
  logic         reset_n;
  logic         scl_m, sda_m;
  logic         sda_line;
  logic         sda_out;
  logic [1:0]   addr_sel;
  logic [7:0]   status_in;
  logic [127:0] regs_out;
  logic         wr_strobe;
  logic [4:0]   wr_index;
  logic         busy;

  always #5 clock = ~clock;
  assign sda_line = sda_m & sda_out;

  i2c_target_regbank #(
    .BASE_ADDR  (7'h20),
    .ADDR_SEL_W (2),
    .REG_COUNT  (16),
    .RO_COUNT   (1),
    .SYNC_STAGES(2)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .scl_in   (scl_m),
    .sda_in   (sda_line),
    .sda_out  (sda_out),
    .addr_sel (addr_sel),
    .status_in(status_in),
    .regs_out (regs_out),
    .wr_strobe(wr_strobe),
    .wr_index (wr_index),
    .busy     (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_regs [16];
  int         m_ptr;
  logic [7:0] m_status;
  int         exp_idx[$];
  int         got_idx[$];
  bit         drv_seen;
  logic [7:0] wq[$];
  bit         mid_en;
  logic [7:0] mid_status;

  function automatic logic [7:0] m_rd(input int i);
    return (i == 0) ? m_status : m_regs[i];
  endfunction

  function automatic logic [127:0] m_vec();
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[8*i +: 8] = m_rd(i);
    return v;
  endfunction

  function automatic int inc_ptr(input int p);
    return (p == 15) ? 0 : p + 1;
  endfunction

  always @(negedge clock) begin
    if (reset_n && wr_strobe) got_idx.push_back(int'(wr_index));
    if (sda_out == 1'b0) drv_seen = 1'b1;
  end

  // ---------------- bus host ----------------
  task automatic clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic bus_start();
    sda_m = 1'b0; clk(8); scl_m = 1'b0;
  endtask

  task automatic bus_rstart();
    clk(2); sda_m = 1'b1; clk(6); scl_m = 1'b1; clk(8); sda_m = 1'b0; clk(8); scl_m = 1'b0;
  endtask

  task automatic bus_stop();
    clk(2); sda_m = 1'b0; clk(6); scl_m = 1'b1; clk(8); sda_m = 1'b1; clk(8);
  endtask

  task automatic wr_bit(input logic b);
    clk(2); sda_m = b; clk(6); scl_m = 1'b1; clk(8); scl_m = 1'b0;
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) wr_bit(b[i]);
    clk(2); sda_m = 1'b1; clk(6); scl_m = 1'b1; clk(4);
    ack = sda_line;
    clk(4); scl_m = 1'b0;
  endtask

  task automatic rd_byte(output logic [7:0] b, input logic nack);
    for (int i = 7; i >= 0; i--) begin
      clk(2); sda_m = 1'b1; clk(6); scl_m = 1'b1; clk(4);
      b[i] = sda_line;
      if (i == 4 && mid_en) begin
        status_in = mid_status;
        mid_en    = 1'b0;
      end
      clk(4); scl_m = 1'b0;
    end
    clk(2); sda_m = nack; clk(6); scl_m = 1'b1; clk(8); scl_m = 1'b0;
  endtask

  task automatic finish_txn(input bit expect_no_drive);
    int n;
    bus_stop();
    clk(4);
    check("busy_after_stop", busy, 1'b0);
    check("strobe_count", got_idx.size(), exp_idx.size());
    n = (got_idx.size() < exp_idx.size()) ? got_idx.size() : exp_idx.size();
    for (int i = 0; i < n; i++) check("strobe_index", got_idx[i], exp_idx[i]);
    check("regs", regs_out, m_vec());
    if (expect_no_drive) check("no_sda_drive", drv_seen, 1'b0);
  endtask

  // Write transfer: address, pointer byte, then the bytes queued in wq.
  task automatic do_write(input logic [6:0] a7, input logic [7:0] p);
    logic ack;
    bit   match, ok;
    got_idx.delete(); exp_idx.delete(); drv_seen = 1'b0;
    match = (a7 == Tgt);
    ok    = match && (p < 8'd16);
    bus_start();
    check("busy_after_start", busy, 1'b1);
    wr_byte({a7, 1'b0}, ack);
    check("addr_ack", ack, !match);
    wr_byte(p, ack);
    check("ptr_ack", ack, !ok);
    if (ok) m_ptr = int'(p);
    foreach (wq[i]) begin
      wr_byte(wq[i], ack);
      check("data_ack", ack, !ok);
      if (ok) begin
        if (m_ptr >= 1) begin
          m_regs[m_ptr] = wq[i];
          exp_idx.push_back(m_ptr);
        end
        m_ptr = inc_ptr(m_ptr);
      end
    end
    finish_txn(!match);
  endtask

  // Pointer write, repeated START, then n bytes read (host NACKs the last).
  task automatic do_read(input logic [7:0] p, input int n);
    logic       ack;
    logic [7:0] b, exp;
    bit         had_mid, ok;
    got_idx.delete(); exp_idx.delete();
    ok = (p < 8'd16);
    had_mid = mid_en;
    bus_start();
    wr_byte({Tgt, 1'b0}, ack);
    check("rd_addr_w_ack", ack, 1'b0);
    wr_byte(p, ack);
    check("rd_ptr_ack", ack, !ok);
    if (ok) m_ptr = int'(p);
    bus_rstart();
    wr_byte({Tgt, 1'b1}, ack);
    check("rd_addr_r_ack", ack, 1'b0);
    for (int k = 0; k < n; k++) begin
      exp = m_rd(m_ptr);
      rd_byte(b, k == n - 1);
      check("rd_data", b, exp);
      if (k == 0 && had_mid) m_status = mid_status;
      if (k < n - 1) m_ptr = inc_ptr(m_ptr);
    end
    clk(6);
    check("release_after_nack", sda_out, 1'b1);
    finish_txn(1'b0);
  endtask

  task automatic set_status(input logic [7:0] s);
    status_in = s;
    m_status  = s;
    clk(4);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    m_ptr = 0;
  endtask

  task automatic check_in_reset(input string tag);
    check({tag, "_sda"}, sda_out, 1'b1);
    check({tag, "_regs"}, regs_out, 128'd0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_strobe"}, wr_strobe, 1'b0);
  endtask

  task automatic recover_from_reset();
    sda_m = 1'b1; clk(1); scl_m = 1'b1; clk(4);
    reset_n = 1'b1;
    model_reset();
    clk(8);
    check("regs_after_reset", regs_out, m_vec());
  endtask

  initial begin
    logic       ack;
    logic [6:0] a7;
    logic [7:0] p;
    int         n;

    reset_n   = 1'b0;
    scl_m     = 1'b1;
    sda_m     = 1'b1;
    addr_sel  = 2'b01;
    status_in = 8'h00;
    m_status  = 8'h00;
    mid_en    = 1'b0;
    mid_status = 8'h00;
    model_reset();
    clk(3);
    #1;
    check_in_reset("reset");
    check("reset_wr_index", wr_index, 5'd0);
    @(negedge clock);
    reset_n = 1'b1;
    clk(4);

    // Write with increment.
    wq = '{8'hA5, 8'h5A};
    do_write(Tgt, 8'h03);

    // Repeated-start read of status then reg1.
    set_status(8'h3C);
    wq = '{8'h77};
    do_write(Tgt, 8'h01);
    do_read(8'h00, 2);

    // Address mismatch: nothing driven, nothing written.
    wq.delete();
    do_write(7'h22, 8'hFF);

    // Pointer out of range; the following read uses the previous pointer.
    wq = '{8'h99, 8'h98};
    do_write(Tgt, 8'h10);
    do_read(8'h12, 1);

    // Wrap through the read-only register.
    wq = '{8'h11, 8'h22, 8'h33};
    do_write(Tgt, 8'h0F);

    // Snapshot coherence: status changes in the middle of the byte being read.
    mid_en = 1'b1;
    mid_status = 8'hC3;
    do_read(8'h00, 2);

    // Reset during the 4th data bit of a write.
    bus_start();
    wr_byte({Tgt, 1'b0}, ack);
    wr_byte(8'h05, ack);
    for (int i = 0; i < 3; i++) wr_bit(1'b1);
    clk(2); sda_m = 1'b0; clk(6); scl_m = 1'b1; clk(4);
    reset_n = 1'b0;
    #1;
    check_in_reset("mid_bit_reset");
    recover_from_reset();
    wq = '{8'hE7, 8'h7E};
    do_write(Tgt, 8'h05);

    // Reset while the address ACK is being driven.
    bus_start();
    for (int i = 7; i >= 0; i--) wr_bit(i == 0 ? 1'b0 : Tgt[i-1]);
    clk(6);
    check("ack_driven", sda_out, 1'b0);
    reset_n = 1'b0;
    #1;
    check_in_reset("ack_reset");
    recover_from_reset();

    // Randomized transactions.
    for (int t = 0; t < 24; t++) begin
      n = $urandom_range(0, 9);
      p = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(16, 255))
                                      : 8'($urandom_range(0, 15));
      if (n == 0) begin
        set_status(8'($urandom));
      end else if (n <= 5) begin
        a7 = ($urandom_range(0, 4) == 0) ? 7'($urandom) : Tgt;
        wq.delete();
        repeat ($urandom_range(0, 4)) wq.push_back(8'($urandom));
        do_write(a7, p);
      end else begin
        mid_en     = ($urandom_range(0, 1) == 1);
        mid_status = 8'($urandom);
        do_read(p, $urandom_range(1, 4));
        mid_en = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
